// File: rtl/mt9v034_pkg.sv
// Shared constants, FIFO entry layout and packer state encoding for the MT9V034 pixel packer.
package mt9v034_pkg;
  localparam int PIX_BYTE_W = 8;
  localparam int PACK_N     = 4;
  localparam int WORD_W     = PIX_BYTE_W * PACK_N;
  localparam int DATA_LSB   = 0;
  localparam int KEEP_LSB   = WORD_W;
  localparam int LAST_BIT   = KEEP_LSB + PACK_N;
  localparam int USER_BIT   = LAST_BIT + 1;
  localparam int ENTRY_W    = USER_BIT + 1;

  typedef enum logic [1:0] {WAIT_SOF, PACK, DROP} pk_state_t;

  function automatic logic [PACK_N-1:0] keep_mask(input logic [2:0] n);
    case (n)
      3'd1:    keep_mask = 4'b0001;
      3'd2:    keep_mask = 4'b0011;
      3'd3:    keep_mask = 4'b0111;
      3'd4:    keep_mask = 4'b1111;
      default: keep_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO; head entry is presented straight from the storage registers, gated to 0 when empty.
module axis_sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_rd, do_wr;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  // a same-cycle read frees the head slot, so a write into a full FIFO is still accepted
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + (AW+1)'(1);
      else if (!do_wr && do_rd) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mt9v034_pixel_packer.sv
// Packs 10-bit mono pixels into 32-bit AXI-Stream words through a FIFO, with overflow drop/resync.
// Optional FRAME_STATS_EN adds frame_width/frame_height/stats_valid of the previous completed frame.
module mt9v034_pixel_packer
  import mt9v034_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_axis_tvalid,
  input  logic [PIX_W-1:0] s_axis_tdata,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             ovf_sticky,
  input  logic             ovf_clr
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]      frame_width,
  output logic [15:0]      frame_height,
  output logic             stats_valid
`endif
);
  pk_state_t             state, state_n;
  logic [1:0]            idx, idx_n, base_idx;
  logic [WORD_W-1:0]     word, word_n, base_word, new_word;
  logic                  sof_pend, sof_n, base_sof;
  logic [PIX_BYTE_W-1:0] pix_byte;
  logic                  wr_req, drop, frame_start, room;
  logic [ENTRY_W-1:0]    wr_entry, fifo_dout;
  logic                  fifo_full, fifo_empty, fifo_rd;
  logic                  unused_lsbs;

  assign pix_byte    = s_axis_tdata[PIX_W-1 -: PIX_BYTE_W];
  assign unused_lsbs = ^s_axis_tdata[PIX_W-PIX_BYTE_W-1:0];
  assign fifo_rd     = m_axis_tvalid && m_axis_tready;
  assign room        = !fifo_full || fifo_rd;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    word_n      = word;
    sof_n       = sof_pend;
    wr_req      = 1'b0;
    wr_entry    = '0;
    drop        = 1'b0;
    frame_start = 1'b0;
    base_idx    = '0;
    base_word   = '0;
    base_sof    = 1'b0;
    new_word    = '0;
    if (s_axis_tvalid) begin
      if (state == PACK && s_axis_tuser && idx != 2'd0) begin
        // frame restart mid-word: flush the partial word, new pixel opens a fresh one
        frame_start = 1'b1;
        wr_req      = 1'b1;
        wr_entry    = {sof_pend, 1'b1, keep_mask({1'b0, idx}), word};
        idx_n       = 2'd1;
        word_n      = {{(WORD_W-PIX_BYTE_W){1'b0}}, pix_byte};
        sof_n       = 1'b1;
      end else if (state == PACK || s_axis_tuser) begin
        frame_start = s_axis_tuser;
        base_idx    = (state == PACK) ? idx : 2'd0;
        base_word   = (state == PACK) ? word : '0;
        base_sof    = ((state == PACK) && sof_pend) || s_axis_tuser;
        new_word    = base_word | (WORD_W'(pix_byte) << {base_idx, 3'b000});
        state_n     = PACK;
        if (base_idx == 2'd3 || s_axis_tlast) begin
          wr_req   = 1'b1;
          wr_entry = {base_sof, s_axis_tlast, keep_mask({1'b0, base_idx} + 3'd1), new_word};
          idx_n    = 2'd0;
          word_n   = '0;
          sof_n    = 1'b0;
        end else begin
          idx_n  = base_idx + 2'd1;
          word_n = new_word;
          sof_n  = base_sof;
        end
      end
      if (wr_req && !room) begin
        drop    = 1'b1;
        state_n = DROP;
        idx_n   = 2'd0;
        word_n  = '0;
        sof_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SOF;
      idx        <= '0;
      word       <= '0;
      sof_pend   <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      word     <= word_n;
      sof_pend <= sof_n;
      if (drop)         ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

  axis_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_req && room),
    .wr_data (wr_entry),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[DATA_LSB +: WORD_W];
  assign m_axis_tkeep  = fifo_dout[KEEP_LSB +: PACK_N];
  assign m_axis_tlast  = fifo_dout[LAST_BIT];
  assign m_axis_tuser  = fifo_dout[USER_BIT];

`ifdef FRAME_STATS_EN
  logic [15:0] col_cnt, row_cnt, last_w;
  logic        frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      last_w       <= '0;
      frame_ok     <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      stats_valid  <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (drop) begin
        frame_ok <= 1'b0;
      end else if (frame_start) begin
        if (frame_ok) begin
          frame_width  <= last_w;
          frame_height <= row_cnt;
          stats_valid  <= 1'b1;
        end
        frame_ok <= 1'b1;
        col_cnt  <= s_axis_tlast ? 16'd0 : 16'd1;
        row_cnt  <= s_axis_tlast ? 16'd1 : 16'd0;
        last_w   <= s_axis_tlast ? 16'd1 : 16'd0;
      end else if (s_axis_tvalid && state == PACK) begin
        if (s_axis_tlast) begin
          last_w  <= sat_inc16(col_cnt);
          col_cnt <= '0;
          row_cnt <= sat_inc16(row_cnt);
        end else begin
          col_cnt <= sat_inc16(col_cnt);
        end
      end
    end
  end
`endif
endmodule
